fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/fetch_decode_if.sv | 19 +
 rtl/fetch_stage_branch_predictor.sv | 64 ++++++
 rtl/fetch_stage.sv | 150 +++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU word, opcode and I-type instruction types plus a
//                small predecode helper used by the fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    localparam int c_WORD_W = 32;

    typedef logic [c_WORD_W-1:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDIU = 6'b001001,
        HALT  = 6'b111111
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } i_t;

    // Conditional branches are the only instructions the BHT predicts
    function automatic logic is_cond_branch(input opcode_t op);
        return (op == BEQ) || (op == BNE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_if
//  Description : Pipeline latch between fetch and decode. Fetch drives it,
//                decode consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_decode_if;
    import cpu_types_pkg::*;

    word_t instruction;
    word_t instr_npc;
    logic  branch_taken;

    modport fetch  (output instruction, instr_npc, branch_taken);
    modport decode (input  instruction, instr_npc, branch_taken);

endinterface
`default_nettype wire

// File: rtl/fetch_stage_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Branch history table of 2-bit saturating counters. Read is
//                combinational from the current counter so a same-cycle
//                update never affects the prediction made in that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             predict_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam logic [1:0] c_WEAK_NT = 2'b01;
    localparam logic [1:0] c_STRONG_T = 2'b11;
    localparam logic [1:0] c_STRONG_NT = 2'b00;

    logic [1:0] r_ctr [ENTRIES];
    logic [1:0] w_upd_cur;
    logic [1:0] w_upd_next;

    // Taken when the counter sits in one of the two upper states
    always_comb begin
        predict_taken = r_ctr[rd_idx][1];
    end

    // Saturating step of the counter being trained
    always_comb begin
        w_upd_cur  = r_ctr[upd_idx];
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != c_STRONG_T) begin
                w_upd_next = w_upd_cur + 2'b01;
            end
        end else begin
            if (w_upd_cur != c_STRONG_NT) begin
                w_upd_next = w_upd_cur - 2'b01;
            end
        end
    end

    // Counter storage; every entry starts weakly not-taken
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_WEAK_NT;
            end
        end else if (upd_en) begin
            r_ctr[upd_idx] <= w_upd_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch with BHT-based branch prediction, decode
//                jump and execute mispredict redirects, flush bubbles and a
//                permanent halt freeze.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT     = 32'h0,
    parameter int          BHT_ENTRIES = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        en,
    input  logic        flush,
    input  logic        jump_instr,
    input  logic [31:0] jump_target,
    input  logic        ex_resolve,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_correct_pc,
    input  logic        halt,
    fetch_decode_if.fetch fdif
);

    localparam int c_IDX_W = $clog2(BHT_ENTRIES);

    word_t r_pc;
    word_t r_instruction;
    word_t r_instr_npc;
    logic  r_branch_taken;
    logic  r_halt_seen;

    i_t    w_instr;
    word_t w_pc_plus4;
    word_t w_pred_target;
    word_t w_next_pc;
    logic  w_is_branch;
    logic  w_bht_taken;
    logic  w_pred_taken;
    logic  w_advance;
    logic  w_redirect;
    logic  w_bubble;
    logic  w_unused;

    // Predictor indexed by word address of the current and resolved PCs
    branch_predictor #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (c_IDX_W)
    ) u_bht (
        .CLK           (CLK),
        .nRST          (nRST),
        .rd_idx        (r_pc[c_IDX_W+1:2]),
        .predict_taken (w_bht_taken),
        .upd_en        (ex_resolve),
        .upd_idx       (ex_pc[c_IDX_W+1:2]),
        .upd_taken     (ex_taken)
    );

    // Predecode the fetched word and form the branch target
    always_comb begin
        w_instr       = i_t'(imemload);
        w_is_branch   = is_cond_branch(w_instr.opcode);
        w_pred_taken  = w_is_branch && w_bht_taken;
        w_pc_plus4    = r_pc + 32'd4;
        w_pred_target = w_pc_plus4 + {{14{w_instr.imm[15]}}, w_instr.imm, 2'b00};
    end

    // Next-PC priority: execute recovery, then decode jump, then prediction
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (ex_mispredict) begin
            w_next_pc = ex_correct_pc;
        end else if (jump_instr) begin
            w_next_pc = jump_target;
        end else if (w_pred_taken) begin
            w_next_pc = w_pred_target;
        end
    end

    // Redirects do not wait for ihit; the outstanding fetch is dropped
    always_comb begin
        w_advance  = en && ihit && !r_halt_seen;
        w_redirect = en && !r_halt_seen && (ex_mispredict || jump_instr);
        w_bubble   = flush || ex_mispredict || jump_instr;
    end

    // PC register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pc <= PC_INIT;
        end else if (w_advance || w_redirect) begin
            r_pc <= w_next_pc;
        end
    end

    // Fetch/decode latch; a redirect without ihit still leaves a bubble
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instruction  <= '0;
            r_instr_npc    <= '0;
            r_branch_taken <= 1'b0;
        end else if (w_advance) begin
            if (w_bubble) begin
                r_instruction  <= '0;
                r_instr_npc    <= '0;
                r_branch_taken <= 1'b0;
            end else begin
                r_instruction  <= imemload;
                r_instr_npc    <= w_pc_plus4;
                r_branch_taken <= w_pred_taken;
            end
        end else if (w_redirect) begin
            r_instruction  <= '0;
            r_instr_npc    <= '0;
            r_branch_taken <= 1'b0;
        end
    end

    // Sticky halt flag, cleared only by reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_halt_seen <= 1'b0;
        end else if (halt) begin
            r_halt_seen <= 1'b1;
        end
    end

    // Drive memory request and the pipeline latch outputs
    always_comb begin
        imemREN           = !r_halt_seen;
        imemaddr          = r_pc;
        fdif.instruction  = r_instruction;
        fdif.instr_npc    = r_instr_npc;
        fdif.branch_taken = r_branch_taken;
    end

    // Fields and address bits the fetch stage does not need
    assign w_unused = ^{ex_pc[31:c_IDX_W+2], ex_pc[1:0], w_instr.rs, w_instr.rt};

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Directed self-checking bench for fetch_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_ADDIU = 32'h24210001;
    localparam logic [31:0] c_BEQ   = 32'h10000003;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        en;
    logic        flush;
    logic        jump_instr;
    logic [31:0] jump_target;
    logic        ex_resolve;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic        ex_mispredict;
    logic [31:0] ex_correct_pc;
    logic        halt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] imem [64];

    fetch_decode_if fdif ();

    fetch_stage #(
        .PC_INIT     (32'h0),
        .BHT_ENTRIES (8)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .ihit          (ihit),
        .imemload      (imemload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .en            (en),
        .flush         (flush),
        .jump_instr    (jump_instr),
        .jump_target   (jump_target),
        .ex_resolve    (ex_resolve),
        .ex_pc         (ex_pc),
        .ex_taken      (ex_taken),
        .ex_mispredict (ex_mispredict),
        .ex_correct_pc (ex_correct_pc),
        .halt          (halt),
        .fdif          (fdif)
    );

    always #5 CLK = ~CLK;

    assign imemload = imem[imemaddr[7:2]];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) imem[i] = c_ADDIU;
        imem[4] = c_BEQ;
        nRST = 1'b0; ihit = 1'b1; en = 1'b1; flush = 1'b0;
        jump_instr = 1'b0; jump_target = '0; ex_resolve = 1'b0; ex_pc = '0;
        ex_taken = 1'b0; ex_mispredict = 1'b0; ex_correct_pc = '0; halt = 1'b0;
        #2;
        checks++;
        if ({imemaddr, imemREN} !== {32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_pc_ren: got %h/%b exp 00000000/1", imemaddr, imemREN);
        end
        checks++;
        if ({fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== 65'h0) begin
            failures++;
            $display("FAIL reset_latch: got %h %h %b exp zeros", fdif.instruction, fdif.instr_npc, fdif.branch_taken);
        end
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        exp_pc = 32'h0;
        checks++;
        if (imemaddr !== exp_pc) begin
            failures++;
            $display("FAIL stream_pc_start: got %h exp %h", imemaddr, exp_pc);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_pc = exp_pc + 32'd4;
            checks++;
            if ({imemaddr, fdif.instr_npc, fdif.instruction} !== {exp_pc, exp_pc, c_ADDIU}) begin
                failures++;
                $display("FAIL stream_step%0d: pc=%h npc=%h ins=%h exp pc=npc=%h ins=%h",
                         k, imemaddr, fdif.instr_npc, fdif.instruction, exp_pc, c_ADDIU);
            end
        end
    endtask

    task automatic test_branch_predict();
        // PC is 0x10 holding BEQ; a same-cycle taken update must not change this prediction
        ex_resolve = 1'b1; ex_pc = 32'h10; ex_taken = 1'b1;
        tick();
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== {32'h14, c_BEQ, 32'h14, 1'b0}) begin
            failures++;
            $display("FAIL beq_not_taken: pc=%h ins=%h npc=%h bt=%b exp 00000014 %h 00000014 0",
                     imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken, c_BEQ);
        end
        // Two more taken resolutions while stalled
        en = 1'b0;
        tick();
        tick();
        ex_resolve = 1'b0;
        checks++;
        if (imemaddr !== 32'h14) begin
            failures++;
            $display("FAIL stall_hold_pc: got %h exp 00000014", imemaddr);
        end
        // Steer back to the branch
        en = 1'b1; ex_mispredict = 1'b1; ex_correct_pc = 32'h10;
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== {32'h10, 65'h0}) begin
            failures++;
            $display("FAIL mispredict_bubble: pc=%h ins=%h npc=%h bt=%b exp 00000010 zeros",
                     imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken);
        end
        tick();
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== {32'h20, c_BEQ, 32'h14, 1'b1}) begin
            failures++;
            $display("FAIL beq_taken: pc=%h ins=%h npc=%h bt=%b exp 00000020 %h 00000014 1",
                     imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken, c_BEQ);
        end
    endtask

    task automatic test_ihit_stall();
        ihit = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if ({imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== {32'h20, c_BEQ, 32'h14, 1'b1}) begin
                failures++;
                $display("FAIL ihit_hold%0d: pc=%h ins=%h npc=%h bt=%b exp 00000020 %h 00000014 1",
                         k, imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken, c_BEQ);
            end
        end
        ex_mispredict = 1'b1; ex_correct_pc = 32'h40;
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken} !== {32'h40, 65'h0}) begin
            failures++;
            $display("FAIL miss_redirect: pc=%h ins=%h npc=%h bt=%b exp 00000040 zeros",
                     imemaddr, fdif.instruction, fdif.instr_npc, fdif.branch_taken);
        end
        ihit = 1'b1;
    endtask

    task automatic test_priority();
        jump_instr = 1'b1; jump_target = 32'h100;
        ex_mispredict = 1'b1; ex_correct_pc = 32'h80;
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if ({imemaddr, fdif.instruction} !== {32'h80, 32'h0}) begin
            failures++;
            $display("FAIL prio_mispredict: pc=%h ins=%h exp 00000080 00000000", imemaddr, fdif.instruction);
        end
        tick();
        jump_instr = 1'b0;
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc} !== {32'h100, 64'h0}) begin
            failures++;
            $display("FAIL jump_redirect: pc=%h ins=%h npc=%h exp 00000100 zeros", imemaddr, fdif.instruction, fdif.instr_npc);
        end
    endtask

    task automatic test_stall_flush();
        tick();
        en = 1'b0;
        tick();
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc} !== {32'h104, c_ADDIU, 32'h104}) begin
            failures++;
            $display("FAIL en_hold: pc=%h ins=%h npc=%h exp 00000104 %h 00000104", imemaddr, fdif.instruction, fdif.instr_npc, c_ADDIU);
        end
        en = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({imemaddr, fdif.instruction, fdif.instr_npc} !== {32'h108, 64'h0}) begin
            failures++;
            $display("FAIL flush_bubble: pc=%h ins=%h npc=%h exp 00000108 zeros", imemaddr, fdif.instruction, fdif.instr_npc);
        end
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if ({imemaddr, imemREN} !== {32'h10C, 1'b0}) begin
            failures++;
            $display("FAIL halt_ren: pc=%h ren=%b exp 0000010c 0", imemaddr, imemREN);
        end
        ex_mispredict = 1'b1; ex_correct_pc = 32'h40;
        tick();
        tick();
        ex_mispredict = 1'b0;
        checks++;
        if ({imemaddr, imemREN, fdif.instr_npc} !== {32'h10C, 1'b0, 32'h10C}) begin
            failures++;
            $display("FAIL halt_frozen: pc=%h ren=%b npc=%h exp 0000010c 0 0000010c", imemaddr, imemREN, fdif.instr_npc);
        end
        // Asynchronous reset between edges
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if ({imemaddr, imemREN, fdif.instruction, fdif.instr_npc} !== {32'h0, 1'b1, 64'h0}) begin
            failures++;
            $display("FAIL async_reset: pc=%h ren=%b ins=%h npc=%h exp 00000000 1 zeros",
                     imemaddr, imemREN, fdif.instruction, fdif.instr_npc);
        end
        tick();
        nRST = 1'b1;
        // BHT must be back to weakly not-taken
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({imemaddr, fdif.instruction, fdif.branch_taken} !== {32'h14, c_BEQ, 1'b0}) begin
            failures++;
            $display("FAIL bht_reset: pc=%h ins=%h bt=%b exp 00000014 %h 0", imemaddr, fdif.instruction, fdif.branch_taken, c_BEQ);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_branch_predict();
        test_ihit_stall();
        test_priority();
        test_stall_flush();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
